conv1d_cfu_sequencer: RTL and testbench

CFU-facing front end that sits directly upstream of the 1-D convolution engine. It accepts CPU commands over the cmd/rsp valid-ready handshake and translates each funct7 into a single-cycle engine command. For reads it captures the engine's registered return word; for start-computation it waits until the engine reports done. It then returns exactly one response per command.

---
 rtl/conv1d_cfu_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_conv1d_cfu_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_cfu_sequencer.sv
// conv1d_cfu_sequencer: CFU command front end for the 1-D convolution engine.
// Latency: write/size/init respond 2 cycles after accept, reads 3, status/invalid/busy 1, start when done.
// Backpressure: one command in flight; cmd_ready is low until the response is taken via rsp_ready.
//
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset (engine itself is not reset here)
//   cmd_*                      - CPU command handshake; funct7 = cmd_payload_function_id[9:3]
//   rsp_*                      - CPU response handshake, payload held stable until accepted
//   eng_cmd/eng_inp0/eng_inp1  - single-cycle engine command (10'h3FF = NOP) and operands
//   eng_ret, eng_done          - engine registered return word and idle/results-valid flag
//
// Optional build macro CONV_SEQ_TIMEOUT_EN: bounds the start-command wait to TIMEOUT_CYCLES
// busy cycles, answering 32'hFFFF_FFFD and setting a sticky flag visible as status bit 1.
module conv1d_cfu_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CYC_W          = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic [9:0]  eng_cmd,
  output logic [31:0] eng_inp0,
  output logic [31:0] eng_inp1,
  input  logic [31:0] eng_ret,
  input  logic        eng_done
);

  localparam logic [9:0] ENG_NOP = 10'h3FF;

`ifdef CONV_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [CYC_W-1:0] TO_LIMIT = CYC_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_GUARD,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [6:0]         op_q, op_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_dat_q, rsp_dat_d;
  logic [9:0]         eng_cmd_q, eng_cmd_d;
  logic [31:0]        eng_inp0_q, eng_inp0_d;
  logic [31:0]        eng_inp1_q, eng_inp1_d;
  logic [CYC_W-1:0]   cnt_q, cnt_d;
  logic               to_flag_q, to_flag_d;

  logic [6:0]         cmd_op;
  logic [CYC_W-1:0]   cnt_inc;

  assign cmd_op                = cmd_payload_function_id[9:3];
  assign cmd_ready             = (state_q == S_IDLE) && !rsp_valid_q;
  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_dat_q;
  assign eng_cmd               = eng_cmd_q;
  assign eng_inp0              = eng_inp0_q;
  assign eng_inp1              = eng_inp1_q;

  // Saturating increment: a runaway engine pins the count at all-ones rather than wrapping.
  assign cnt_inc = (cnt_q == {CYC_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    eng_cmd_d   = ENG_NOP;       // commands are one-cycle pulses
    eng_inp0_d  = eng_inp0_q;
    eng_inp1_d  = eng_inp1_q;
    cnt_d       = cnt_q;
    to_flag_d   = to_flag_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d       = cmd_op;
          eng_inp0_d = cmd_payload_inputs_0;
          eng_inp1_d = cmd_payload_inputs_1;
          if (cmd_op == 7'd8) begin
            rsp_dat_d   = {30'b0, to_flag_q, eng_done};
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else if (cmd_op > 7'd8) begin
            rsp_dat_d   = 32'hFFFF_FFFF;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else if (!eng_done) begin
            // Engine still busy: refuse rather than corrupt an in-flight computation.
            rsp_dat_d   = 32'hFFFF_FFFE;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            eng_cmd_d = {3'b000, cmd_op};
            state_d   = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        case (op_q)
          7'd3, 7'd6, 7'd7: state_d = S_CAPTURE;
          7'd5:             state_d = S_GUARD;
          default: begin
            rsp_dat_d   = 32'h0;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end
        endcase
      end

      S_CAPTURE: begin
        // Engine registered the read at the ISSUE edge, so eng_ret is valid now.
        rsp_dat_d   = eng_ret;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end

      S_GUARD: begin
        // eng_done is still settling low after the start edge; do not trust it yet.
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        // The reported count includes the cycle in which done is observed,
        // i.e. it equals the number of cycles spent in this state.
        cnt_d = cnt_inc;
        if (eng_done) begin
          rsp_dat_d   = 32'(cnt_inc);
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (TO_EN && (cnt_inc == TO_LIMIT)) begin
          rsp_dat_d   = 32'hFFFF_FFFD;
          rsp_valid_d = 1'b1;
          to_flag_d   = 1'b1;
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 7'd0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'h0;
      eng_cmd_q   <= ENG_NOP;
      eng_inp0_q  <= 32'h0;
      eng_inp1_q  <= 32'h0;
      cnt_q       <= '0;
      to_flag_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      eng_cmd_q   <= eng_cmd_d;
      eng_inp0_q  <= eng_inp0_d;
      eng_inp1_q  <= eng_inp1_d;
      cnt_q       <= cnt_d;
      to_flag_q   <= to_flag_d;
    end
  end

endmodule

// File: tb/tb_conv1d_cfu_sequencer.sv
// Bench for conv1d_cfu_sequencer: randomized commands against a behavioural engine
// and a transaction-level model of the expected response data and latency.
module tb_conv1d_cfu_sequencer;

  localparam int TO = 16;
  localparam logic [9:0] NOP = 10'h3FF;
`ifdef CONV_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id = 10'h0;
  logic [31:0] cmd_payload_inputs_0 = 32'h0;
  logic [31:0] cmd_payload_inputs_1 = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_payload_outputs_0;
  logic [9:0]  eng_cmd;
  logic [31:0] eng_inp0;
  logic [31:0] eng_inp1;
  logic [31:0] eng_ret;
  logic        eng_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv1d_cfu_sequencer #(.TIMEOUT_CYCLES(TO), .CYC_W(32)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0),
    .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .eng_cmd(eng_cmd), .eng_inp0(eng_inp0), .eng_inp1(eng_inp1),
    .eng_ret(eng_ret), .eng_done(eng_done)
  );

  // ---------------- behavioural engine ----------------
  logic [31:0] e_in [16];
  logic [31:0] e_k  [16];
  logic [31:0] e_out[16];
  logic        e_done_r = 1'b1;
  logic        force_busy = 1'b0;
  int          e_busy = 0;
  int          next_busy_len = 1;
  logic [31:0] e_ret_r = 32'h0;

  assign eng_done = e_done_r & ~force_busy;
  assign eng_ret  = e_ret_r;

  initial begin
    for (int i = 0; i < 16; i++) begin
      e_in[i] = 32'h0; e_k[i] = 32'h0; e_out[i] = 32'h0;
    end
  end

  always @(posedge clk) begin
    if (eng_cmd == 10'd5) begin
      e_done_r <= 1'b0;
      e_busy   <= next_busy_len;
      for (int i = 0; i < 16; i++) e_out[i] <= e_in[i] ^ e_k[i];
    end else begin
      if (e_busy > 0) begin
        e_busy <= e_busy - 1;
        if (e_busy == 1) e_done_r <= 1'b1;
      end
      case (eng_cmd)
        10'd0: for (int i = 0; i < 16; i++) begin
                 e_in[i] <= 32'h0; e_k[i] <= 32'h0; e_out[i] <= 32'h0;
               end
        10'd1: e_in[eng_inp0[3:0]] <= eng_inp1;
        10'd2: e_k[eng_inp0[3:0]]  <= eng_inp1;
        10'd3: e_ret_r <= e_out[eng_inp0[3:0]];
        10'd6: e_ret_r <= e_in[eng_inp0[3:0]];
        10'd7: e_ret_r <= e_k[eng_inp0[3:0]];
        default: ;
      endcase
    end
  end

  // ---------------- reference model state ----------------
  logic [31:0] sh_in[16];
  logic [31:0] sh_k [16];
  logic [31:0] sh_out[16];
  logic        m_to = 1'b0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      sh_in[i] = 32'h0; sh_k[i] = 32'h0; sh_out[i] = 32'h0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_start();
    for (int i = 0; i < 16; i++) sh_out[i] = sh_in[i] ^ sh_k[i];
  endtask

  // Issue one command and check everything the DUT shows until the response is taken.
  task automatic do_cmd(input logic [6:0] f7, input logic [31:0] a0, input logic [31:0] a1,
                        input int stall, input int blen, output logic [31:0] got);
    logic [9:0]  ecmd;
    logic [31:0] exp;
    int          lat;
    int          k;
    bit          seen;
    logic [3:0]  ad;
    ad = a0[3:0];
    @(negedge clk);
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    ecmd = NOP;
    lat  = 1;
    if (f7 == 7'd8) begin
      exp = {30'b0, m_to, eng_done};
    end else if (f7 > 7'd8) begin
      exp = 32'hFFFF_FFFF;
    end else if (!eng_done) begin
      exp = 32'hFFFF_FFFE;
    end else begin
      ecmd = {3'b0, f7};
      lat  = 2;
      exp  = 32'h0;
      case (f7)
        7'd0: for (int i = 0; i < 16; i++) begin
                sh_in[i] = 32'h0; sh_k[i] = 32'h0; sh_out[i] = 32'h0;
              end
        7'd1: sh_in[ad] = a1;
        7'd2: sh_k[ad]  = a1;
        7'd3: begin lat = 3; exp = sh_out[ad]; end
        7'd6: begin lat = 3; exp = sh_in[ad]; end
        7'd7: begin lat = 3; exp = sh_k[ad]; end
        7'd5: begin
          model_start();
          if (TO_EN && blen > TO) begin
            lat = TO + 3; exp = 32'hFFFF_FFFD; m_to = 1'b1;
          end else begin
            lat = blen + 3; exp = 32'(blen);
          end
        end
        default: ;
      endcase
    end
    next_busy_len = blen;
    cmd_valid = 1'b1;
    cmd_payload_function_id = {f7, 3'($urandom_range(0, 7))};
    cmd_payload_inputs_0 = a0;
    cmd_payload_inputs_1 = a1;
    @(posedge clk);
    k = 0;
    seen = 1'b0;
    // cmd_valid stays high: a pending second command must not be taken before the handshake
    while (!seen && k < lat + 2) begin
      @(negedge clk);
      k++;
      chk("eng_cmd", {22'b0, eng_cmd}, (k == 1) ? {22'b0, ecmd} : {22'b0, NOP});
      if (k == 1 && ecmd != NOP) begin
        chk("eng_inp0", eng_inp0, a0);
        chk("eng_inp1", eng_inp1, a1);
      end
      chk("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
      if (rsp_valid) seen = 1'b1;
    end
    got = rsp_payload_outputs_0;
    if (!seen) begin
      chk("rsp_timeout", 32'd0, 32'd1);
    end else begin
      chk("latency", 32'(k), 32'(lat));
      chk("rsp_data", rsp_payload_outputs_0, exp);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_data", rsp_payload_outputs_0, exp);
      chk("stall_ready", {31'b0, cmd_ready}, 32'd0);
      chk("stall_eng_cmd", {22'b0, eng_cmd}, {22'b0, NOP});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_drop", {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!eng_done && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("engine_idle", {31'b0, eng_done}, 32'd1);
  endtask

  initial begin
    logic [31:0] got;
    logic [6:0]  f7;
    int          sel;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_eng_cmd", {22'b0, eng_cmd}, {22'b0, NOP});
    chk("rst_payload", rsp_payload_outputs_0, 32'h0);
    chk("rst_inp0", eng_inp0, 32'h0);
    chk("rst_inp1", eng_inp1, 32'h0);
    reset = 1'b0;

    // directed cases pinned by literal values
    do_cmd(7'd1, 32'h0, 32'h0706_0504, 0, 1, got);
    chk("lit_write", got, 32'h0);
    do_cmd(7'd6, 32'h0, 32'h0, 0, 1, got);
    chk("lit_read_in", got, 32'h0706_0504);
    do_cmd(7'd5, 32'h0, 32'h0, 0, 8, got);
    chk("lit_start8", got, 32'd8);
    do_cmd(7'd9, 32'h0, 32'h0, 5, 1, got);
    chk("lit_invalid", got, 32'hFFFF_FFFF);
    do_cmd(7'd8, 32'h0, 32'h0, 0, 1, got);
    chk("lit_status", got, 32'h1);

    // engine unexpectedly busy: refused without an engine pulse
    force_busy = 1'b1;
    do_cmd(7'd2, 32'h3, 32'h1234_5678, 1, 1, got);
    chk("lit_busy", got, 32'hFFFF_FFFE);
    do_cmd(7'd8, 32'h0, 32'h0, 0, 1, got);
    chk("lit_status_busy", got, 32'h0);
    force_busy = 1'b0;

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 12);
      if (sel >= 10) f7 = 7'($urandom_range(9, 127));
      else if (sel == 0 && $urandom_range(0, 3) != 0) f7 = 7'd1;
      else f7 = 7'(sel);
      do_cmd(f7, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 12), got);
    end

    // reset asserted in the middle of a start wait
    @(negedge clk);
    next_busy_len = 20;
    cmd_valid = 1'b1;
    cmd_payload_function_id = {7'd5, 3'b000};
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    model_start();
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("midrst_eng_cmd", {22'b0, eng_cmd}, {22'b0, NOP});
    chk("midrst_payload", rsp_payload_outputs_0, 32'h0);
    reset = 1'b0;
    m_to = 1'b0;
    wait_done(40);
    do_cmd(7'd8, 32'h0, 32'h0, 0, 1, got);
    chk("lit_status_after_rst", got, 32'h1);

`ifdef CONV_SEQ_TIMEOUT_EN
    do_cmd(7'd5, 32'h0, 32'h0, 2, 30, got);
    chk("lit_timeout", got, 32'hFFFF_FFFD);
    do_cmd(7'd1, 32'h1, 32'hAA, 0, 1, got);
    chk("lit_busy_after_to", got, 32'hFFFF_FFFE);
    wait_done(40);
    do_cmd(7'd8, 32'h0, 32'h0, 0, 1, got);
    chk("lit_status_to", got, 32'h3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so a stuck handshake can never hang the run.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
